// File: rtl/serial_receiver.sv
// UART-style receiver: 2-flop rx synchronizer, mid-bit sampling, parity/framing checks.
// Each completed word is held on a valid/ack handshake; a newer word overwrites it and flags overrun.
module serial_receiver #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int PARITY    = 0,
  parameter int NUM_BITS  = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  output logic [NUM_BITS-1:0] data,
  output logic                valid,
  input  logic                ack,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun
);

  localparam int NUM_CYCLES  = CLK_FREQ / BAUD_RATE - 1;
  localparam int HALF_CYCLES = NUM_CYCLES / 2;
  localparam int CW          = $clog2(NUM_CYCLES + 1);
  localparam int BW          = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic                rx_meta_q, rx_s_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                done;
  logic                bit_hit;
  logic                par_exp;

  logic [NUM_BITS-1:0] data_q;
  logic                valid_q, parity_err_q, frame_err_q, overrun_q;

  assign bit_hit = (cnt_q == CW'(NUM_CYCLES));

  always_comb begin
    case (PARITY)
      1:       par_exp = ~^shift_q;
      2:       par_exp = ^shift_q;
      3:       par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        // A line back high at mid start bit was only a glitch.
        if (cnt_q == CW'(HALF_CYCLES)) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_hit) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[NUM_BITS-1:1]};
          if (bit_cnt_q == BW'(NUM_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_hit) begin
          cnt_d   = '0;
          perr_d  = (rx_s_q != par_exp);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_hit) begin
          cnt_d = '0;
          if (!rx_s_q) ferr_d = 1'b1;
          // Leaving mid stop bit lets a back-to-back start edge be seen on time.
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            done      = 1'b1;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (done) begin
      data_q       <= shift_q;
      parity_err_q <= perr_q;
      frame_err_q  <= ferr_d;
      valid_q      <= 1'b1;
      overrun_q    <= valid_q & ~ack;
    end else if (valid_q && ack) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
